cs_sample_packer: RTL

Multi-channel successor to the single-channel performance sample-to-transmit stage. Accepts LSB samples from `NCH` coherent samplers over per-channel 4-phase req/ack handshakes, arbitrates round-robin and packs `NBLSB` bits per sample into bytes. Buffers bytes in a FIFO and drains them to the send controller over the `transmit`/`is_transmitting` handshake. Sits between the coherent sampler array and the send controller in the TRNG top level.

---
 rtl/cs_packer_pkg.sv | 23 ++
 rtl/cs_byte_fifo.sv | 54 +++++
 rtl/cs_sample_packer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cs_packer_pkg.sv
// Shared types and constants for the coherent-sampler packer.
// Holds the channel/TX FSM encodings and the NBLSB legality helper.
package cs_packer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        WAIT_REQ,
        CAPTURE,
        ACK
    } ch_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT,
        TX_BUSY
    } tx_state_t;

    function automatic bit nblsb_divides_byte(input int n);
        return (n > 0) && (n <= BYTE_W) && ((BYTE_W % n) == 0);
    endfunction

endpackage

// File: rtl/cs_byte_fifo.sv
// Synchronous byte FIFO, depth 2**LOG, with occupancy output.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module cs_byte_fifo #(
    parameter int LOG = 4
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         i_push,
    input  logic [7:0]   i_wdata,
    input  logic         i_pop,
    output logic [7:0]   o_rdata,
    output logic         o_full,
    output logic         o_empty,
    output logic [LOG:0] o_level
);
    import cs_packer_pkg::*;

    localparam int DEPTH = 1 << LOG;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [LOG-1:0]    r_wrPtr;
    logic [LOG-1:0]    r_rdPtr;
    logic [LOG:0]      r_level;
    logic              w_pushOk;
    logic              w_popOk;

    assign o_full   = (r_level == (LOG+1)'(DEPTH));
    assign o_empty  = (r_level == '0);
    assign o_level  = r_level;
    assign o_rdata  = r_mem[r_rdPtr];
    assign w_popOk  = i_pop && !o_empty;
    assign w_pushOk = i_push && (!o_full || w_popOk);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_popOk)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_pushOk, w_popOk})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_pushOk) r_mem[r_wrPtr] <= i_wdata;
    end

endmodule

// File: rtl/cs_sample_packer.sv
// Round-robin packer of coherent-sampler LSBs into bytes, buffered and drained to the send controller.
// Define CS_PACKER_DROP_CNT_EN to add the saturating drop_cnt output.
module cs_sample_packer #(
    parameter int NCH      = 2,
    parameter int CNT_W    = 16,
    parameter int NBLSB    = 1,
    parameter int FIFO_LOG = 4
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH-1:0]       cs_req,
    input  logic [NCH*CNT_W-1:0] cs_cnt,
    output logic [NCH-1:0]       cs_ack,
    input  logic                 is_transmitting,
    output logic                 transmit,
    output logic [7:0]           tx_byte,
    output logic [FIFO_LOG:0]    fifo_level,
    output logic                 overflow
`ifdef CS_PACKER_DROP_CNT_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);
    import cs_packer_pkg::*;

    localparam int         PTR_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [2:0] BIT_STEP = 3'(NBLSB % BYTE_W);
    localparam logic [2:0] LAST_BIT = 3'(BYTE_W - NBLSB);

    if (!nblsb_divides_byte(NBLSB)) begin : g_bad_nblsb
        $error("cs_sample_packer: NBLSB must be 1, 2, 4 or 8");
    end

    logic [NCH-1:0]    r_reqMeta;
    logic [NCH-1:0]    r_reqSync;
    ch_state_t         r_chState [NCH];
    ch_state_t         w_chNext  [NCH];
    logic [NCH-1:0]    w_capReq;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W:0]    w_idxSum;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W-1:0]  w_grantIdx;
    logic              w_grantValid;
    logic [BYTE_W-1:0] w_sample;
    logic [BYTE_W-1:0] w_shiftNext;
    logic [BYTE_W-1:0] r_shift;
    logic [2:0]        r_bitCnt;
    logic              r_byteDone;
    tx_state_t         r_txState;
    tx_state_t         w_txNext;
    logic              w_pop;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_rdata;
    logic              w_unusedCnt;

    // Only the low NBLSB bits of each count are packed; the rest are deliberately ignored.
    assign w_unusedCnt = ^cs_cnt;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_reqMeta <= '0;
            r_reqSync <= '0;
        end else begin
            r_reqMeta <= cs_req;
            r_reqSync <= r_reqMeta;
        end
    end

    // Rotating search from the pointer; disabled channels never compete for a grant.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_idxSum     = '0;
        w_idx        = '0;
        for (int g = 0; g < NCH; g++) begin
            w_capReq[g] = (r_chState[g] == CAPTURE) && ch_en[g];
        end
        for (int k = 0; k < NCH; k++) begin
            w_idxSum = (PTR_W+1)'(r_ptr) + (PTR_W+1)'(k);
            if (w_idxSum >= (PTR_W+1)'(NCH)) w_idxSum = w_idxSum - (PTR_W+1)'(NCH);
            w_idx = w_idxSum[PTR_W-1:0];
            if (!w_grantValid && w_capReq[w_idx]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = w_idx;
            end
        end
    end

    always_comb begin
        cs_ack = '0;
        for (int g = 0; g < NCH; g++) begin
            w_chNext[g] = r_chState[g];
            case (r_chState[g])
                WAIT_REQ: if (r_reqSync[g] && ch_en[g]) w_chNext[g] = CAPTURE;
                CAPTURE:  if (!ch_en[g] || (w_grantValid && w_grantIdx == PTR_W'(g))) w_chNext[g] = ACK;
                ACK:      if (!r_reqSync[g]) w_chNext[g] = WAIT_REQ;
                default:  w_chNext[g] = WAIT_REQ;
            endcase
            cs_ack[g] = (r_chState[g] == ACK);
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < NCH; g++) begin
            if (!n_reset) r_chState[g] <= WAIT_REQ;
            else          r_chState[g] <= w_chNext[g];
        end
    end

    // New sample enters at the top so the earliest sample ends up in the byte's LSBs.
    always_comb begin
        w_sample = '0;
        for (int g = 0; g < NCH; g++) begin
            if (w_grantIdx == PTR_W'(g)) w_sample[NBLSB-1:0] = cs_cnt[g*CNT_W +: NBLSB];
        end
        w_shiftNext = BYTE_W'({w_sample, r_shift} >> NBLSB);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_shift    <= '0;
            r_bitCnt   <= '0;
            r_byteDone <= 1'b0;
            r_ptr      <= '0;
        end else begin
            r_byteDone <= 1'b0;
            if (w_grantValid) begin
                r_shift <= w_shiftNext;
                r_ptr   <= (w_grantIdx == PTR_W'(NCH-1)) ? '0 : w_grantIdx + 1'b1;
                if (r_bitCnt == LAST_BIT) begin
                    r_bitCnt   <= '0;
                    r_byteDone <= 1'b1;
                end else begin
                    r_bitCnt <= r_bitCnt + BIT_STEP;
                end
            end
        end
    end

    cs_byte_fifo #(
        .LOG(FIFO_LOG)
    ) u_fifo (
        .clk    (clk),
        .n_reset(n_reset),
        .i_push (r_byteDone),
        .i_wdata(r_shift),
        .i_pop  (w_pop),
        .o_rdata(w_rdata),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_level(fifo_level)
    );

    assign w_pop  = (r_txState == TX_IDLE) && !w_empty && !is_transmitting;
    assign w_drop = r_byteDone && w_full && !w_pop;

    always_comb begin
        w_txNext = r_txState;
        case (r_txState)
            TX_IDLE: if (w_pop) w_txNext = TX_WAIT;
            TX_WAIT: if (is_transmitting) w_txNext = TX_BUSY;
            TX_BUSY: if (!is_transmitting) w_txNext = TX_IDLE;
            default: w_txNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_txState <= TX_IDLE;
            transmit  <= 1'b0;
            tx_byte   <= '0;
            overflow  <= 1'b0;
        end else begin
            r_txState <= w_txNext;
            transmit  <= w_pop;
            if (w_pop) tx_byte <= w_rdata;
            if (w_drop) overflow <= 1'b1;
        end
    end

`ifdef CS_PACKER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            drop_cnt <= '0;
        end else if (w_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule
